dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Accepts one load/store request at a
//  time over a valid/ready handshake and services it after a fixed latency. Returns a response
//  over a second valid/ready handshake. Sits between pip_reg_m (initiator) and the word array.
//  Its stall-visible ready lets the hazard unit freeze the pipeline when memory is slow.
// PARAMETERS
//  ADDR_WIDTH   32    byte-address width of req_addr_i
//  DATA_WIDTH   32    word width; fixed at 32 (byte/half lanes assume 4 lanes)
//  DEPTH_WORDS  1024  words in array; power of 2; index = addr[$clog2(DEPTH_WORDS)+1:2]
//  LATENCY      2     clock edges from accepting edge to rsp_valid_o high; legal range >=1
// PORTS
//  clk_i           in   1           clock, rising edge
//  rst_ni          in   1           asynchronous reset, active-low
//  req_valid_i     in   1           request present
//  req_ready_o     out  1           responder can accept; high only in IDLE
//  req_we_i        in   1           1=store, 0=load
//  req_size_i      in   2           00=byte 01=half 10=word (11 treated as word)
//  req_unsigned_i  in   1           load zero-extend (LBU/LHU) when 1, sign-extend when 0
//  req_addr_i      in   ADDR_WIDTH  byte address
//  req_wdata_i     in   DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid_o     out  1           response present
//  rsp_ready_i     in   1           initiator consumes response
//  rsp_rdata_o     out  DATA_WIDTH  load data, extended; 0 for stores and errors
//  rsp_err_o       out  1           misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE -> BUSY -> RESP -> IDLE. Reset (rst_ni=0, async) -> IDLE.
//    Reset outputs: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Array not reset.
//  - Accept on edge where req_valid_i & req_ready_o. All req_* fields registered then.
//    Inputs are ignored afterwards until the next accept.
//  - LATENCY=1: IDLE -> RESP directly on accept. LATENCY>1: BUSY, with the counter loaded with
//    LATENCY-1 and decremented each edge. Counter width $clog2(LATENCY+1).
//    BUSY -> RESP on the edge where the counter is 1.
//  - Commit edge = the edge entering RESP.
//    Store: the write is performed on the commit edge.
//    Load: rsp_rdata_o is registered on the commit edge.
//  - Write lanes use addr[1:0]. Byte: lane addr[1:0]. Half: lanes {addr[1],0}+{0,1}.
//    Word: all 4. Unselected bytes unchanged.
//  - Load extract uses the same lanes, then sign/zero extends per req_unsigned_i.
//  - RESP: rsp_valid_o=1, and data/err are held stable until rsp_ready_i=1.
//    The edge with rsp_valid_o & rsp_ready_i -> IDLE and clears rsp_valid_o.
//  - rsp_ready_i may be high before RESP; it has no effect outside RESP.
//  - Throughput: at most one transaction per LATENCY+1 cycles. No request pipelining.
//  - Address wrap: bits above the index are ignored. Address DEPTH_WORDS*4 aliases word 0.
//  - Reset mid-BUSY: transaction dropped, no write.
//    Reset mid-RESP: the write has already committed and the response is lost.
//  - A load and store to the same word in consecutive transactions: the load sees the new data.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN defined:
//    - Half with addr[0]=1, or word with addr[1:0]!=0 -> rsp_err_o=1 in RESP, rsp_rdata_o=0,
//      and no write occurs. The latency is unchanged.
//  DMEM_MISALIGN_CHK_EN undefined:
//    - rsp_err_o tied 0.
//    - Misaligned low bits forced to natural alignment: half uses addr[1], word uses lanes 0-3.
//      The access proceeds normally.
// TESTING
//  1 Word store: SW 0xDEADBEEF @0x10. Then LW @0x10 -> rdata=0xDEADBEEF, err=0.
//    rsp_valid_o rises exactly LATENCY edges after each accept.
//  2 Byte sign extension: SB 0x80 @0x13 into word 0x00000000.
//    LB @0x13 -> 0xFFFFFF80. LBU @0x13 -> 0x00000080. LW @0x10 -> 0x80000000.
//  3 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP.
//    rsp_valid_o, rdata and err stay stable, req_ready_o=0 throughout, and a new req_valid_i is
//    not accepted. Release -> IDLE next edge.
//  4 Misaligned (CHK_EN): SH 0x1234 @0x21 -> err=1, rdata=0, and a later LW @0x20 is unchanged.
//    Without the macro: err=0 and halfword 0x1234 is written at 0x20.
//  5 Reset mid-op: SW 0x55 @0x40 accepted, then rst_ni low during BUSY (LATENCY=3).
//    Outputs go to reset values immediately. LW @0x40 returns the old value.
//  6 Wrap: DEPTH_WORDS=1024, SW 0xA5A5A5A5 @0x1000 -> LW @0x0 returns 0xA5A5A5A5.
//    Repeat scenarios 1-3 with LATENCY=1.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory load/store responder with fixed latency and valid/ready handshakes
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  commit;

  logic                  reqWeQ;
  logic [1:0]            reqSizeQ;
  logic                  reqUnsQ;
  logic [IDX_W+1:0]      reqAddrQ;
  logic [DATA_WIDTH-1:0] reqWdataQ;

  logic                  opWe;
  logic [1:0]            opSize;
  logic                  opUns;
  logic [IDX_W+1:0]      opAddr;
  logic [DATA_WIDTH-1:0] opWdata;
  logic [IDX_W-1:0]      opIdx;
  logic [1:0]            opOff;

  logic [3:0]            byteEn;
  logic [DATA_WIDTH-1:0] wrWord;
  logic [DATA_WIDTH-1:0] rdWord;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ldVal;
  logic                  misaligned;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rspRdata;

  // Address bits above the word index only alias; they never select storage.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr_i[ADDR_WIDTH-1:IDX_W+2];

  assign accept = req_valid_i && (state == IDLE);

  // With LATENCY=1 the accept edge is also the commit edge, so live request fields are used.
  assign commit = rst_ni && (((state == IDLE) && accept && (LATENCY == 1)) ||
                             ((state == BUSY) && (cnt == CNT_W'(1))));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept) begin
          stateNext = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      reqWeQ    <= 1'b0;
      reqSizeQ  <= 2'b00;
      reqUnsQ   <= 1'b0;
      reqAddrQ  <= '0;
      reqWdataQ <= '0;
    end else begin
      if (accept) begin
        cnt       <= CNT_W'(LATENCY - 1);
        reqWeQ    <= req_we_i;
        reqSizeQ  <= req_size_i;
        reqUnsQ   <= req_unsigned_i;
        reqAddrQ  <= req_addr_i[IDX_W+1:0];
        reqWdataQ <= req_wdata_i;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign opWe    = (state == IDLE) ? req_we_i               : reqWeQ;
  assign opSize  = (state == IDLE) ? req_size_i             : reqSizeQ;
  assign opUns   = (state == IDLE) ? req_unsigned_i         : reqUnsQ;
  assign opAddr  = (state == IDLE) ? req_addr_i[IDX_W+1:0]  : reqAddrQ;
  assign opWdata = (state == IDLE) ? req_wdata_i            : reqWdataQ;
  assign opIdx   = opAddr[IDX_W+1:2];
  assign opOff   = opAddr[1:0];

`ifdef DMEM_MISALIGN_CHK_EN
  assign misaligned = ((opSize == 2'b01) && opOff[0]) ||
                      (opSize[1] && (opOff != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane selection ignores low address bits a size cannot use, which naturally aligns halves and words.
  always_comb begin
    byteEn  = 4'b0000;
    wrWord  = '0;
    ldVal   = '0;
    rdWord  = mem[opIdx];
    shifted = rdWord >> {opOff, 3'b000};
    case (opSize)
      2'b00: begin
        byteEn = 4'b0001 << opOff;
        wrWord = {4{opWdata[7:0]}};
        ldVal  = opUns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        byteEn = opOff[1] ? 4'b1100 : 4'b0011;
        wrWord = {2{opWdata[15:0]}};
        if (opOff[1]) begin
          ldVal = opUns ? {16'h0000, rdWord[31:16]} : {{16{rdWord[31]}}, rdWord[31:16]};
        end else begin
          ldVal = opUns ? {16'h0000, rdWord[15:0]} : {{16{rdWord[15]}}, rdWord[15:0]};
        end
      end
      default: begin
        byteEn = 4'b1111;
        wrWord = opWdata;
        ldVal  = rdWord;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (commit && opWe && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[opIdx][8*b +: 8] <= wrWord[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rspRdata <= '0;
    end else if (commit) begin
      rspRdata <= (opWe || misaligned) ? '0 : ldVal;
    end
  end

  assign rsp_rdata_o = rspRdata;

`ifdef DMEM_MISALIGN_CHK_EN
  logic rspErr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rspErr <= 1'b0;
    end else if (commit) begin
      rspErr <= misaligned;
    end
  end

  assign rsp_err_o = rspErr;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 1, 2 and 3
module tb_dmem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid [N];
  logic        reqReady [N];
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic        reqUns = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid [N];
  logic        rspReady [N];
  logic [31:0] rspRdata [N];
  logic        rspErr [N];

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gDut
    dmem_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(g + 1)
    ) u (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(reqValid[g]), .req_ready_o(reqReady[g]),
      .req_we_i(reqWe), .req_size_i(reqSize), .req_unsigned_i(reqUns),
      .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
      .rsp_valid_o(rspValid[g]), .rsp_ready_i(rspReady[g]),
      .rsp_rdata_o(rspRdata[g]), .rsp_err_o(rspErr[g])
    );
  end

  // Behavioural model: one outstanding transaction per DUT, memory as a plain word array.
  logic        busy [N];
  int          elapsed [N];
  logic        tWe [N];
  logic [1:0]  tSize [N];
  logic        tUns [N];
  logic [31:0] tAddr [N];
  logic [31:0] tWdata [N];
  logic [31:0] expRdata [N];
  logic        expErr [N];
  logic [31:0] mdl [N][1024];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic void modelCommit(input int k);
    int idx, off, first, nb;
    logic [31:0] v;
    logic mis;
    idx = int'((tAddr[k] / 4) % 1024);
    off = int'(tAddr[k] % 4);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = ((tSize[k] == 2'd1) && (off % 2 == 1)) || ((tSize[k] >= 2'd2) && (off != 0));
`endif
    if (tSize[k] == 2'd0) begin first = off; nb = 1; end
    else if (tSize[k] == 2'd1) begin first = (off / 2) * 2; nb = 2; end
    else begin first = 0; nb = 4; end
    expErr[k] = mis;
    expRdata[k] = '0;
    if (mis) return;
    if (tWe[k]) begin
      for (int b = 0; b < nb; b++) mdl[k][idx][8*(first+b) +: 8] = tWdata[k][8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < nb; b++) v[8*b +: 8] = mdl[k][idx][8*(first+b) +: 8];
      if (!tUns[k] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
      expRdata[k] = v;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        busy[k] = 1'b0; elapsed[k] = 0; expRdata[k] = '0; expErr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (busy[k] && elapsed[k] >= k + 1) begin
          if (rspReady[k]) busy[k] = 1'b0;
        end else if (busy[k]) begin
          elapsed[k]++;
          if (elapsed[k] == k + 1) modelCommit(k);
        end else if (reqValid[k]) begin
          busy[k] = 1'b1; elapsed[k] = 1;
          tWe[k] = reqWe; tSize[k] = reqSize; tUns[k] = reqUns;
          tAddr[k] = reqAddr; tWdata[k] = reqWdata;
          if (k == 0) modelCommit(k);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && checkOn) begin
      for (int k = 0; k < N; k++) begin
        chk("req_ready", k, 32'(reqReady[k]), 32'(!busy[k]));
        chk("rsp_valid", k, 32'(rspValid[k]), 32'(busy[k] && elapsed[k] >= k + 1));
        if (busy[k] && elapsed[k] >= k + 1) begin
          chk("rsp_rdata", k, rspRdata[k], expRdata[k]);
          chk("rsp_err", k, 32'(rspErr[k]), 32'(expErr[k]));
        end
      end
    end
  end

  task automatic txn(input int k, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     input bit stray, output logic [31:0] rd, output logic er);
    bit got;
    @(posedge clk); #2;
    reqWe = we; reqSize = size; reqUns = uns; reqAddr = addr; reqWdata = wdata;
    reqValid[k] = 1'b1;
    rspReady[k] = (hold == 0);
    @(posedge clk); #2;
    reqValid[k] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (rspValid[k]) got = 1'b1;
    end
    chk("rsp_timeout", k, 32'(got), 32'd1);
    rd = rspRdata[k];
    er = rspErr[k];
    if (hold > 0) begin
      if (stray) begin
        reqWe = 1'b1; reqSize = 2'b10; reqAddr = 32'h10; reqWdata = 32'h11111111;
        reqValid[k] = 1'b1;
      end
      repeat (hold) @(negedge clk);
      reqValid[k] = 1'b0;
      rspReady[k] = 1'b1;
    end
    @(posedge clk); #2;
    rspReady[k] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    for (int k = 0; k < N; k++) begin
      reqValid[k] = 1'b0; rspReady[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < N; k++) begin
      chk("reset_ready", k, 32'(reqReady[k]), 32'd1);
      chk("reset_valid", k, 32'(rspValid[k]), 32'd0);
      chk("reset_rdata", k, rspRdata[k], 32'd0);
      chk("reset_err", k, 32'(rspErr[k]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    checkOn = 1'b1;

    // Word, byte-extension and backpressure scenarios at LATENCY=2 then LATENCY=1.
    for (int k = 1; k >= 0; k--) begin
      txn(k, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
      chk("sw_rdata_zero", k, rd, 32'd0);
      txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
      chk("lw_deadbeef", k, rd, 32'hDEADBEEF);
      chk("lw_err", k, 32'(er), 32'd0);
      txn(k, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
      txn(k, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 0, 1'b0, rd, er);
      txn(k, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd, er);
      chk("lb_sext", k, rd, 32'hFFFFFF80);
      txn(k, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 1'b0, rd, er);
      chk("lbu_zext", k, rd, 32'h00000080);
      txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
      chk("lw_after_sb", k, rd, 32'h80000000);
      txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er);
      chk("bp_rdata", k, rd, 32'h80000000);
      txn(k, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
      chk("bp_no_stray_store", k, rd, 32'h80000000);
    end

    // Misaligned halfword store.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 0, 1'b0, rd, er);
    txn(1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, 0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("sh_mis_err", 1, 32'(er), 32'd1);
    chk("sh_mis_rdata", 1, rd, 32'd0);
    txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_mis", 1, rd, 32'hCAFEF00D);
`else
    chk("sh_mis_err", 1, 32'(er), 32'd0);
    txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_mis", 1, rd, 32'hCAFE1234);
    txn(1, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 0, 1'b0, rd, er);
    chk("lh_forced_align", 1, rd, 32'hFFFFCAFE);
`endif

    // Address wrap.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A5A5A5, 0, 1'b0, rd, er);
    txn(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0, rd, er);
    chk("wrap_lw", 1, rd, 32'hA5A5A5A5);

    // Reset while BUSY at LATENCY=3 drops the store.
    txn(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 0, 1'b0, rd, er);
    @(posedge clk); #2;
    reqWe = 1'b1; reqSize = 2'b10; reqAddr = 32'h40; reqWdata = 32'h55;
    reqValid[2] = 1'b1;
    @(posedge clk); #2;
    reqValid[2] = 1'b0;
    chk("busy_ready_low", 2, 32'(reqReady[2]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("async_rst_ready", k, 32'(reqReady[k]), 32'd1);
      chk("async_rst_valid", k, 32'(rspValid[k]), 32'd0);
      chk("async_rst_rdata", k, rspRdata[k], 32'd0);
      chk("async_rst_err", k, 32'(rspErr[k]), 32'd0);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    txn(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_reset", 2, rd, 32'h12345678);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
